pixel_packer: RTL and testbench
===============================

# pixel_packer

Packs a stream of 24-bit RGB pixels into the 32-bit AXI-Stream words consumed by the video DMA: 4 pixels → 3 words, so a 640-pixel line becomes 480 words. Sits between the Mandelbrot pixel-colour pipeline and the `out_stream_*` port of `pixel_generator`. Generates `tuser` (start of frame) and `tlast` (end of line) on packed words, honours downstream backpressure, and flags misaligned framing.

## Interface
- `X_PIXELS`, default 640: pixels per line; must be a multiple of 4.
- `Y_SIZE`, default 480: lines per frame; used only for the line counter wrap.
- `out_stream_aclk` in 1: the single clock.
- `periph_resetn` in 1: reset, asynchronous assert, active-low.
- `in_tdata` in 24: pixel, `{R,G,B}`.
- `in_tvalid` in 1: pixel valid.
- `in_tready` out 1: pixel accepted when `in_tvalid && in_tready`.
- `in_tuser` in 1: first pixel of frame.
- `in_tlast` in 1: last pixel of line.
- `out_stream_tdata` out 32: packed word.
- `out_stream_tkeep` out 4: constant `4'hF`.
- `out_stream_tvalid` out 1: word valid.
- `out_stream_tready` in 1: downstream ready.
- `out_stream_tuser` out 1: SOF, on the first word of frame.
- `out_stream_tlast` out 1: EOL, on the last word of line.
- `err_align` out 1: sticky framing error; cleared only by reset.
- `line_count` out 10: lines completed in the current frame.

## Operation
- `phase` counter runs 0..3, one step per accepted pixel; `res` is a residual register of 24 bits.
- Phase 0 (p0): `res <= p0`; no word emitted.
- Phase 1 (p1): emit `{p1[7:0], res[23:0]}`; `res[15:0] <= p1[23:8]`.
- Phase 2 (p2): emit `{p2[15:0], res[15:0]}`; `res[7:0] <= p2[23:16]`.
- Phase 3 (p3): emit `{p3, res[7:0]}`; `phase <= 0`.
- `tuser`: a `sof_pend` flag is set by a pixel accepted with `in_tuser`. It drives `tuser` on the next emitted word, then clears.
- `tlast`: set on the word emitted by the pixel carrying `in_tlast`.
- Misaligned EOL (`in_tlast` at phase 0, 1 or 2):
  - Emit that phase's word with `tlast=1`. At phase 0 the word is `{8'h00, p0}`.
  - Discard the leftover residual bits, force `phase <= 0` and set `err_align`.
- SOF at phase ≠ 0:
  - Discard the residual and treat the pixel as p0 of phase 0.
  - Clear any pending `tlast` and set `err_align`.
- A line whose pixel count at EOL ≠ `X_PIXELS` sets `err_align`; the line is still emitted as described above.
- `line_count`:
  - Increments on each handshaked `tlast` word.
  - Clears to 0 on SOF acceptance, and on reaching `Y_SIZE`.
- SOF and EOL on the same pixel (1-pixel line) follow the phase 0 EOL rule: `tuser=1` and `tlast=1` on word `{8'h00, p0}`.

## Timing
- Output is a single registered stage: a word appears on `out_stream_*` the cycle after the pixel that produced it is accepted.
- `in_tready = !out_stream_tvalid || out_stream_tready`. This is a combinational path from `out_stream_tready`, which is permitted.
- Throughput: 1 pixel per cycle sustained under constant ready; 3 words per 4 cycles.
- `out_stream_tdata`, `tuser` and `tlast` are held stable while `tvalid && !tready`. `tvalid` never drops without a handshake.
- `tvalid` clears on a handshake unless a new word is loaded in the same cycle.
- Phase 0 acceptances do not load the output register, so `tvalid` may drop for one cycle there.
- Reset values:
  - Outputs: `out_stream_tvalid=0`, `tdata=0`, `tuser=0`, `tlast=0`, `err_align=0`, `line_count=0`.
  - Internal: `phase=0`, `res=0`, `sof_pend=0`.
  - `in_tready` evaluates to 1 once reset is released.
- Reset mid-line drops any partial word and the pending output word.

## Structure
- `pixel_packer_pkg` holds:
  - `PIX_W=24`, `WORD_W=32`.
  - The phase type, a 2-bit enum `PH0..PH3`.
  - The `{tdata, tuser, tlast}` output word struct.
- Single module. The output register may be factored as `axis_out_reg`, a one-word AXIS holding stage, if reused elsewhere.
- Pixel counter width is `$clog2(X_PIXELS+1)`.

## Test plan
- **Aligned packing:** pixels `112233, 445566, 778899, AABBCC`, ready=1 → words `66112233`, `88994455`, `AABBCC77`.
- **Full frame:** 640×480 pixels, SOF on pixel 0, EOL every 640 pixels, under random `out_stream_tready` (PRBS, about 50%) →
  - 480 words per line, `tlast` only on word 479, `tuser` only on word 0 of the frame.
  - No data corruption or stalls; `err_align=0`.
- **Backpressure hold:** hold `out_stream_tready=0` for 20 cycles mid-line → `tdata`, `tuser`, `tlast` stable; `in_tready=0` throughout; no pixels lost.
- **Misaligned EOL:** EOL on pixel 6 of a line (phase 2) → last word `{p6[15:0], p5[23:8]}` with `tlast=1`; `err_align=1`; next line packs from phase 0.
- **Mid-line SOF:** SOF at phase 2 → the new p0 restarts packing; the next word has `tuser=1`; `err_align=1`; `line_count=0`.
- **Reset mid-word:** assert `periph_resetn=0` after 2 pixels with a word pending → all outputs 0 immediately; after release the first 4 pixels produce correctly packed words.

Source files
------------

// File: rtl/pixel_packer_pkg.sv
// Shared types and helpers for the 24-bit RGB to 32-bit AXI-Stream pixel packer.
package pixel_packer_pkg;

  localparam int PIX_W  = 24;
  localparam int WORD_W = 32;
  localparam int LC_W   = 10;

  typedef enum logic [1:0] {
    PH0 = 2'd0,
    PH1 = 2'd1,
    PH2 = 2'd2,
    PH3 = 2'd3
  } phase_e;

  typedef struct packed {
    logic [WORD_W-1:0] tdata;
    logic              tuser;
    logic              tlast;
  } axis_word_t;

  // Word produced by the pixel arriving in phase ph; in PH0 only an EOL pixel emits, zero-padded.
  function automatic logic [WORD_W-1:0] pack_word(input phase_e ph,
                                                  input logic [PIX_W-1:0] pix,
                                                  input logic [PIX_W-1:0] res);
    case (ph)
      PH0:     pack_word = {8'h00, pix};
      PH1:     pack_word = {pix[7:0], res};
      PH2:     pack_word = {pix[15:0], res[15:0]};
      PH3:     pack_word = {pix, res[7:0]};
      default: pack_word = {8'h00, pix};
    endcase
  endfunction

endpackage

// File: rtl/pixel_packer_axis_out_reg.sv
// One-word AXI-Stream holding stage: loads a word, holds it until the consumer takes it.
module pixel_packer_axis_out_reg
  import pixel_packer_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_load,
  input  axis_word_t i_word,
  input  logic       i_ready,
  output logic       o_valid,
  output axis_word_t o_word
);

  logic       r_valid;
  axis_word_t r_word;

  // Holding register; contents only change on a load so they stay stable under backpressure.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= 1'b0;
      r_word  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_word  <= i_word;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end else begin
      r_valid <= r_valid;
    end
  end

  assign o_valid = r_valid;
  assign o_word  = r_word;

endmodule

// File: rtl/pixel_packer.sv
// Packs 24-bit RGB pixels into 32-bit AXI-Stream words (4 pixels -> 3 words) with
// SOF/EOL framing, downstream backpressure and a sticky misalignment flag.
module pixel_packer
  import pixel_packer_pkg::*;
#(
  parameter int X_PIXELS = 640,
  parameter int Y_SIZE   = 480
) (
  input  logic              out_stream_aclk,
  input  logic              periph_resetn,
  input  logic [PIX_W-1:0]  in_tdata,
  input  logic              in_tvalid,
  output logic              in_tready,
  input  logic              in_tuser,
  input  logic              in_tlast,
  output logic [WORD_W-1:0] out_stream_tdata,
  output logic [3:0]        out_stream_tkeep,
  output logic              out_stream_tvalid,
  input  logic              out_stream_tready,
  output logic              out_stream_tuser,
  output logic              out_stream_tlast,
  output logic              err_align,
  output logic [LC_W-1:0]   line_count
);

  localparam int CNT_W = $clog2(X_PIXELS + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(X_PIXELS);
  localparam logic [CNT_W-1:0] CNT_OVER = CNT_W'(X_PIXELS + 1);
  localparam logic [LC_W-1:0]  LC_LAST  = LC_W'(Y_SIZE - 1);

  phase_e           r_phase, w_phase_nxt, w_ph_eff;
  logic [PIX_W-1:0] r_res, w_res_nxt;
  logic             r_sof_pend, w_sof_pend_nxt;
  logic [CNT_W-1:0] r_pix_cnt, w_pix_cnt_nxt, w_pix_cnt_base, w_pix_cnt_inc;
  logic             r_err, w_err_nxt;
  logic [LC_W-1:0]  r_line_cnt, w_line_cnt_nxt;
  logic             w_acc, w_load, w_in_ready, w_sof_mid, w_hs_last;
  logic             w_out_valid;
  axis_word_t       w_word, w_out_word;

  assign w_in_ready = !w_out_valid || out_stream_tready;
  assign w_acc      = in_tvalid && w_in_ready;
  assign w_sof_mid  = in_tuser && (r_phase != PH0);
  assign w_hs_last  = w_out_valid && out_stream_tready && w_out_word.tlast;

  // A mid-line SOF restarts packing, so that pixel is treated as phase 0.
  always_comb begin
    if (w_sof_mid) begin
      w_ph_eff = PH0;
    end else begin
      w_ph_eff = r_phase;
    end
  end

  // Pixels seen in the current line, including the one being accepted; saturates one past a full line.
  always_comb begin
    if (in_tuser) begin
      w_pix_cnt_base = {CNT_W{1'b0}};
    end else begin
      w_pix_cnt_base = r_pix_cnt;
    end
    if (w_pix_cnt_base == CNT_OVER) begin
      w_pix_cnt_inc = CNT_OVER;
    end else begin
      w_pix_cnt_inc = w_pix_cnt_base + CNT_W'(1);
    end
  end

  // Packing next-state: phase, residual, SOF pending, line pixel count and error flag.
  always_comb begin
    w_phase_nxt    = r_phase;
    w_res_nxt      = r_res;
    w_sof_pend_nxt = r_sof_pend;
    w_pix_cnt_nxt  = r_pix_cnt;
    w_err_nxt      = r_err;
    w_load         = 1'b0;
    w_word.tdata   = pack_word(w_ph_eff, in_tdata, r_res);
    w_word.tuser   = r_sof_pend || in_tuser;
    w_word.tlast   = in_tlast;
    if (w_acc) begin
      w_load         = in_tlast || (w_ph_eff != PH0);
      w_sof_pend_nxt = !w_load && (r_sof_pend || in_tuser);
      case (w_ph_eff)
        PH0: begin
          w_res_nxt   = in_tdata;
          w_phase_nxt = PH1;
        end
        PH1: begin
          w_res_nxt[15:0] = in_tdata[23:8];
          w_phase_nxt     = PH2;
        end
        PH2: begin
          w_res_nxt[7:0] = in_tdata[23:16];
          w_phase_nxt    = PH3;
        end
        PH3:     w_phase_nxt = PH0;
        default: w_phase_nxt = PH0;
      endcase
      w_err_nxt = r_err || w_sof_mid ||
                  (in_tlast && ((w_ph_eff != PH3) || (w_pix_cnt_inc != CNT_FULL)));
      if (in_tlast) begin
        w_phase_nxt   = PH0;
        w_res_nxt     = {PIX_W{1'b0}};
        w_pix_cnt_nxt = {CNT_W{1'b0}};
      end else begin
        w_pix_cnt_nxt = w_pix_cnt_inc;
      end
    end else begin
      w_load = 1'b0;
    end
  end

  // Lines completed in the frame; an accepted SOF wins over a same-cycle EOL handshake.
  always_comb begin
    if (w_acc && in_tuser) begin
      w_line_cnt_nxt = {LC_W{1'b0}};
    end else if (w_hs_last) begin
      if (r_line_cnt == LC_LAST) begin
        w_line_cnt_nxt = {LC_W{1'b0}};
      end else begin
        w_line_cnt_nxt = r_line_cnt + LC_W'(1);
      end
    end else begin
      w_line_cnt_nxt = r_line_cnt;
    end
  end

  // State registers.
  always_ff @(posedge out_stream_aclk or negedge periph_resetn) begin
    if (!periph_resetn) begin
      r_phase    <= PH0;
      r_res      <= {PIX_W{1'b0}};
      r_sof_pend <= 1'b0;
      r_pix_cnt  <= {CNT_W{1'b0}};
      r_err      <= 1'b0;
      r_line_cnt <= {LC_W{1'b0}};
    end else begin
      r_phase    <= w_phase_nxt;
      r_res      <= w_res_nxt;
      r_sof_pend <= w_sof_pend_nxt;
      r_pix_cnt  <= w_pix_cnt_nxt;
      r_err      <= w_err_nxt;
      r_line_cnt <= w_line_cnt_nxt;
    end
  end

  pixel_packer_axis_out_reg u_out_reg (
    .i_clk   (out_stream_aclk),
    .i_rst_n (periph_resetn),
    .i_load  (w_load),
    .i_word  (w_word),
    .i_ready (out_stream_tready),
    .o_valid (w_out_valid),
    .o_word  (w_out_word)
  );

  assign in_tready         = w_in_ready;
  assign out_stream_tvalid = w_out_valid;
  assign out_stream_tdata  = w_out_word.tdata;
  assign out_stream_tuser  = w_out_word.tuser;
  assign out_stream_tlast  = w_out_word.tlast;
  assign out_stream_tkeep  = 4'hF;
  assign err_align         = r_err;
  assign line_count        = r_line_cnt;

endmodule

// File: tb/tb_pixel_packer.sv
// Randomised bench for pixel_packer: a bit-stream reference model scores every handshaked
// word, framing flag and line counter, with hand-computed words pinning the model.
module tb_pixel_packer;

  localparam int XP = 16;
  localparam int YS = 6;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [23:0] in_tdata = 24'h0;
  logic        in_tvalid = 1'b0;
  logic        in_tready;
  logic        in_tuser = 1'b0;
  logic        in_tlast = 1'b0;
  logic [31:0] out_tdata;
  logic [3:0]  out_tkeep;
  logic        out_tvalid;
  logic        out_tready;
  logic        out_tuser;
  logic        out_tlast;
  logic        err_align;
  logic [9:0]  line_count;

  int n_chk = 0;
  int n_fail = 0;
  int rdy_mode = 0;

  logic [33:0] exp_q[$];
  logic [33:0] obs_q[$];

  always #5 clk = ~clk;

  pixel_packer #(.X_PIXELS(XP), .Y_SIZE(YS)) dut (
    .out_stream_aclk   (clk),
    .periph_resetn     (rst_n),
    .in_tdata          (in_tdata),
    .in_tvalid         (in_tvalid),
    .in_tready         (in_tready),
    .in_tuser          (in_tuser),
    .in_tlast          (in_tlast),
    .out_stream_tdata  (out_tdata),
    .out_stream_tkeep  (out_tkeep),
    .out_stream_tvalid (out_tvalid),
    .out_stream_tready (out_tready),
    .out_stream_tuser  (out_tuser),
    .out_stream_tlast  (out_tlast),
    .err_align         (err_align),
    .line_count        (line_count)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Downstream ready: 0 = always ready, 1 = random ~50%, 2 = held low.
  initial begin
    out_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       out_tready = 1'b1;
        1:       out_tready = 1'($urandom_range(0, 1));
        default: out_tready = 1'b0;
      endcase
    end
  end

  // Reference model: pixels are appended to a bit stream, 32-bit words are cut off the bottom,
  // and an EOL flushes (zero-padding only if that pixel produced no word) and drops the rest.
  initial begin
    logic [63:0] mbuf;
    int          mbits;
    int          mpix;
    logic        msof;
    logic        merr;
    int          mline;
    logic        prev_stall;
    logic [33:0] prev_word;
    logic [33:0] e;
    logic        emitted;
    mbuf = '0; mbits = 0; mpix = 0; msof = 1'b0; merr = 1'b0; mline = 0;
    prev_stall = 1'b0; prev_word = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
        mbuf = '0; mbits = 0; mpix = 0; msof = 1'b0; merr = 1'b0; mline = 0;
        prev_stall = 1'b0;
      end else begin
        chk("in_tready", 64'(in_tready), 64'(!out_tvalid || out_tready));
        chk("tkeep", 64'(out_tkeep), 64'hF);
        chk("err_align", 64'(err_align), 64'(merr));
        chk("line_count", 64'(line_count), 64'(mline));
        if (prev_stall) begin
          chk("hold_valid", 64'(out_tvalid), 64'd1);
          chk("hold_word", 64'({out_tdata, out_tuser, out_tlast}), 64'(prev_word));
        end
        prev_stall = out_tvalid && !out_tready;
        prev_word  = {out_tdata, out_tuser, out_tlast};
        if (out_tvalid && out_tready) begin
          if (exp_q.size() == 0) begin
            chk("spurious_word", 64'({out_tdata, out_tuser, out_tlast}), 64'h0);
          end else begin
            e = exp_q.pop_front();
            chk("word", 64'({out_tdata, out_tuser, out_tlast}), 64'(e));
          end
          obs_q.push_back({out_tdata, out_tuser, out_tlast});
          if (out_tlast) mline = (mline == YS - 1) ? 0 : mline + 1;
        end
        if (in_tvalid && in_tready) begin
          if (in_tuser) begin
            if (mbits != 0) merr = 1'b1;
            mbuf = '0; mbits = 0; mpix = 0; msof = 1'b1; mline = 0;
          end
          mbuf = mbuf | (64'(in_tdata) << mbits);
          mbits += 24;
          mpix++;
          emitted = 1'b0;
          if (mbits >= 32) begin
            exp_q.push_back({mbuf[31:0], msof, in_tlast});
            msof = 1'b0; mbuf = mbuf >> 32; mbits -= 32; emitted = 1'b1;
          end
          if (in_tlast) begin
            if (!emitted) begin
              exp_q.push_back({mbuf[31:0], msof, 1'b1});
              msof = 1'b0;
            end
            if (mpix != XP || mbits != 0) merr = 1'b1;
            mbuf = '0; mbits = 0; mpix = 0;
          end
        end
      end
    end
  end

  // Called just after a rising edge; returns just after the edge that accepted the pixel.
  task automatic send_pix(input logic [23:0] d, input logic sof, input logic eol);
    int waitc = 0;
    in_tdata = d; in_tuser = sof; in_tlast = eol; in_tvalid = 1'b1;
    @(negedge clk);
    while (!in_tready && waitc < 1000) begin
      @(negedge clk);
      waitc++;
    end
    chk("accept_timeout", 64'(waitc < 1000), 64'd1);
    @(posedge clk);
    #1;
    in_tvalid = 1'b0; in_tuser = 1'b0; in_tlast = 1'b0;
  endtask

  task automatic drain();
    int c = 0;
    while ((exp_q.size() != 0 || out_tvalid) && c < 500) begin
      @(negedge clk);
      c++;
    end
    chk("drain_timeout", 64'(c < 500), 64'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_tvalid", 64'(out_tvalid), 64'd0);
    chk("rst_tdata", 64'(out_tdata), 64'd0);
    chk("rst_tuser_tlast", 64'({out_tuser, out_tlast}), 64'd0);
    chk("rst_err", 64'(err_align), 64'd0);
    chk("rst_line_count", 64'(line_count), 64'd0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    chk("rst_in_tready", 64'(in_tready), 64'd1);
  endtask

  task automatic send_line(input int n, input logic sof_first);
    for (int p = 0; p < n; p++) send_pix(24'($urandom), sof_first && p == 0, p == n - 1);
  endtask

  initial begin
    int base;
    logic [33:0] hold_w;
    logic [23:0] px[7];
    logic [23:0] s0, s1;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    chk("reset_in_tready", 64'(in_tready), 64'd1);
    chk("reset_tvalid", 64'(out_tvalid), 64'd0);

    // Aligned packing with literal words and one-cycle latency.
    base = obs_q.size();
    send_pix(24'h112233, 1'b0, 1'b0);
    chk("p0_no_word", 64'(out_tvalid), 64'd0);
    send_pix(24'h445566, 1'b0, 1'b0);
    chk("p1_latency", 64'({out_tvalid, out_tdata}), {31'd0, 1'b1, 32'h66112233});
    send_pix(24'h778899, 1'b0, 1'b0);
    send_pix(24'hAABBCC, 1'b0, 1'b0);
    drain();
    chk("aligned_w0", 64'(obs_q[base]),     64'({32'h66112233, 2'b00}));
    chk("aligned_w1", 64'(obs_q[base + 1]), 64'({32'h88994455, 2'b00}));
    chk("aligned_w2", 64'(obs_q[base + 2]), 64'({32'hAABBCC77, 2'b00}));

    // Two full frames under random ready and random input gaps.
    base = obs_q.size();
    rdy_mode = 1;
    for (int f = 0; f < 2; f++)
      for (int l = 0; l < YS; l++)
        for (int p = 0; p < XP; p++) begin
          if ($urandom_range(0, 3) == 0)
            repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
          send_pix(24'($urandom), l == 0 && p == 0, p == XP - 1);
        end
    @(negedge clk);
    rdy_mode = 0;
    drain();
    chk("frame_word_count", 64'(obs_q.size() - base), 64'(2 * YS * XP * 3 / 4));
    chk("frame_first_tuser", 64'(obs_q[base][1]), 64'd1);
    chk("frame_err", 64'(err_align), 64'd0);
    chk("frame_line_wrap", 64'(line_count), 64'd0);

    // Backpressure hold mid-line for 20 cycles.
    fork
      begin
        for (int p = 0; p < 12; p++) send_pix(24'($urandom), 1'b0, 1'b0);
      end
      begin
        repeat (3) @(negedge clk);
        rdy_mode = 2;
        repeat (3) @(negedge clk);
        hold_w = {out_tdata, out_tuser, out_tlast};
        chk("bp_valid", 64'(out_tvalid), 64'd1);
        for (int k = 0; k < 20; k++) begin
          @(negedge clk);
          chk("bp_in_tready", 64'(in_tready), 64'd0);
          chk("bp_hold", 64'({out_tdata, out_tuser, out_tlast}), 64'(hold_w));
        end
        rdy_mode = 0;
      end
    join
    for (int p = 12; p < XP; p++) send_pix(24'($urandom), 1'b0, p == XP - 1);
    drain();
    chk("bp_line_count", 64'(line_count), 64'd1);

    // Reset with a word pending, then clean packing afterwards.
    @(negedge clk);
    rdy_mode = 2;
    @(posedge clk);
    #2;
    send_pix(24'h010203, 1'b0, 1'b0);
    send_pix(24'h040506, 1'b0, 1'b0);
    @(negedge clk);
    chk("pend_before_reset", 64'(out_tvalid), 64'd1);
    rdy_mode = 0;
    do_reset();
    base = obs_q.size();
    send_pix(24'hC0FFEE, 1'b0, 1'b0);
    send_pix(24'h123456, 1'b0, 1'b0);
    send_pix(24'hABCDEF, 1'b0, 1'b0);
    send_pix(24'h987654, 1'b0, 1'b0);
    drain();
    chk("post_rst_count", 64'(obs_q.size() - base), 64'd3);
    chk("post_rst_w0", 64'(obs_q[base]),     64'({32'h56C0FFEE, 2'b00}));
    chk("post_rst_w1", 64'(obs_q[base + 1]), 64'({32'hCDEF1234, 2'b00}));
    chk("post_rst_w2", 64'(obs_q[base + 2]), 64'({32'h987654AB, 2'b00}));

    // Mid-line SOF at phase 2.
    do_reset();
    send_line(XP, 1'b0);
    drain();
    chk("sof_pre_line_count", 64'(line_count), 64'd1);
    chk("sof_pre_err", 64'(err_align), 64'd0);
    send_pix(24'($urandom), 1'b0, 1'b0);
    send_pix(24'($urandom), 1'b0, 1'b0);
    s0 = 24'h5A5A01;
    s1 = 24'h3C3C02;
    send_pix(s0, 1'b1, 1'b0);
    send_pix(s1, 1'b0, 1'b0);
    drain();
    chk("sof_word", 64'(obs_q[obs_q.size() - 1]), 64'({s1[7:0], s0, 2'b10}));
    chk("sof_err", 64'(err_align), 64'd1);
    chk("sof_line_count", 64'(line_count), 64'd0);
    for (int p = 2; p < XP; p++) send_pix(24'($urandom), 1'b0, p == XP - 1);
    drain();

    // Misaligned EOL on pixel 6 (phase 2), then a clean line.
    do_reset();
    base = obs_q.size();
    for (int p = 0; p < 7; p++) begin
      px[p] = 24'($urandom);
      send_pix(px[p], 1'b0, p == 6);
    end
    drain();
    chk("mis_count", 64'(obs_q.size() - base), 64'd5);
    chk("mis_last", 64'(obs_q[base + 4]), 64'({px[6][15:0], px[5][23:8], 2'b01}));
    chk("mis_err", 64'(err_align), 64'd1);
    base = obs_q.size();
    s0 = 24'hFEDCBA;
    s1 = 24'h13579B;
    send_pix(s0, 1'b0, 1'b0);
    send_pix(s1, 1'b0, 1'b0);
    for (int p = 2; p < XP; p++) send_pix(24'($urandom), 1'b0, p == XP - 1);
    drain();
    chk("mis_next_w0", 64'(obs_q[base]), 64'({s1[7:0], s0, 2'b00}));
    chk("mis_line_count", 64'(line_count), 64'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
